// File: rtl/irq_event_pkg.sv
// Shared opcode constants, data width and the priority-encode helper
// for the IRQ event controller.
package irq_event_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_READ   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_MASK   = 3'd2,
    OP_PRIO   = 3'd3,
    OP_TSTAMP = 3'd4
  } op_e;

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic logic [4:0] lowest_idx(input logic [DATA_W-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_event_controller_if.sv
// Custom-instruction port bundle between the processor (master) and the
// IRQ event controller (slave).
interface irq_event_controller_if;
  logic                             clk_en;
  logic                             start;
  logic [2:0]                       n;
  logic [irq_event_pkg::DATA_W-1:0] dataa;
  logic [irq_event_pkg::DATA_W-1:0] result;
  logic                             done;

  modport master (output clk_en, start, n, dataa, input result, done);
  modport slave  (input clk_en, start, n, dataa, output result, done);
endinterface

// File: rtl/irq_edge_sync.sv
// One event input: SYNC_STAGES-deep synchronizer followed by a
// rising-edge detector against the previous synchronized value.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_event,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_event};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_event_controller.sv
// Event-latching interrupt controller behind a single-cycle custom
// instruction. Optional capture timestamp enabled by IRQ_TIMESTAMP_EN.
module irq_event_controller
  import irq_event_pkg::*;
#(
  parameter int NUM_EVENTS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] events,
  irq_event_controller_if.slave cpu,
  output logic                  interrupt
);

  logic [NUM_EVENTS-1:0] w_rise;
  logic [NUM_EVENTS-1:0] r_pending;
  logic [NUM_EVENTS-1:0] r_mask;
  logic                  r_interrupt;
  logic                  r_done;
  logic [DATA_W-1:0]     r_result;
  logic [NUM_EVENTS-1:0] w_pm;
  logic [NUM_EVENTS-1:0] w_clr;
  logic                  w_accept;
  logic                  w_irq_nxt;
  logic [DATA_W-1:0]     w_tstamp;
  logic [DATA_W-1:0]     w_op_result;
  logic                  w_unused_dataa;

  function automatic logic [DATA_W-1:0] zext(input logic [NUM_EVENTS-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[NUM_EVENTS-1:0] = v;
    return r;
  endfunction

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_sync
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_event(events[i]),
      .o_rise (w_rise[i])
    );
  end

  assign w_accept       = cpu.start & cpu.clk_en;
  assign w_pm           = r_pending & r_mask;
  assign w_irq_nxt      = |w_pm;
  assign w_clr          = (w_accept && cpu.n == OP_CLEAR) ? cpu.dataa[NUM_EVENTS-1:0] : '0;
  assign w_unused_dataa = &{1'b0, cpu.dataa[DATA_W-1:NUM_EVENTS]};

  always_comb begin
    w_op_result = '0;
    case (cpu.n)
      OP_READ:   w_op_result = zext(r_pending);
      OP_CLEAR:  w_op_result = zext(r_pending);
      OP_MASK:   w_op_result = zext(r_mask);
      OP_PRIO:   w_op_result = {w_irq_nxt, 26'd0, lowest_idx(zext(w_pm))};
      OP_TSTAMP: w_op_result = w_tstamp;
      default:   w_op_result = '0;
    endcase
  end

  // Edge set is OR-ed after the clear so a coincident edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending   <= '0;
      r_mask      <= '0;
      r_interrupt <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_pending   <= (r_pending & ~w_clr) | w_rise;
      r_interrupt <= w_irq_nxt;
      if (cpu.clk_en) begin
        r_done   <= cpu.start;
        r_result <= cpu.start ? w_op_result : '0;
        if (w_accept && cpu.n == OP_MASK) r_mask <= cpu.dataa[NUM_EVENTS-1:0];
      end
    end
  end

`ifdef IRQ_TIMESTAMP_EN
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_tstamp;

  // Captured value is the count seen in the first cycle interrupt is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_tstamp <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (!r_interrupt && w_irq_nxt) r_tstamp <= r_cnt + 32'd1;
    end
  end

  assign w_tstamp = r_tstamp;
`else
  assign w_tstamp = '0;
`endif

  assign cpu.done   = r_done;
  assign cpu.result = r_result;
  assign interrupt  = r_interrupt;

endmodule

// File: doc/irq_event_controller.md
IRQ_EVENT_CONTROLLER -- requirements
Module: irq_event_controller

Interface
REQ-001 Parameter NUM_EVENTS, default 8, SHALL set the number of event inputs (legal 1..31).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth per event input (legal 2..3).
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 events  input  NUM_EVENTS  SHALL carry asynchronous peripheral event levels; a rising edge is one event.
REQ-006 clk_en  input  1  SHALL be the custom-instruction clock enable; low stalls the instruction path.
REQ-007 start  input  1  SHALL request one custom-instruction operation when high with clk_en high.
REQ-008 n  input  3  SHALL be the opcode for the operation.
REQ-009 dataa  input  32  SHALL be the operand.
REQ-010 result  output  32  SHALL be the operation result, valid while done is high.
REQ-011 done  output  1  SHALL pulse high one cycle per completed operation.
REQ-012 interrupt  output  1  SHALL be the registered level request to the processor's wait-for-interrupt instruction.

Function
REQ-013 Each event SHALL pass through SYNC_STAGES flops, then rising-edge detection against the previous synchronized value.
REQ-014 A detected edge SHALL set pending[i] in the following cycle; further edges on a set bit SHALL be absorbed.
REQ-015 interrupt SHALL equal the registered OR of (pending & mask), i.e. one cycle after pending/mask change.
REQ-016 Operation accepted in cycle T (start & clk_en) SHALL assert done and result in cycle T+1; fixed latency 1, back-to-back starts every cycle permitted.
REQ-017 While clk_en is low, done, result and mask SHALL hold; pending clear SHALL not occur; event capture SHALL continue.
REQ-018 n=0 SHALL return pending, zero-extended, without side effects.
REQ-019 n=1 SHALL clear pending bits where dataa is 1 (write-1-to-clear) and return pending value before the clear.
REQ-020 n=2 SHALL load mask from dataa[NUM_EVENTS-1:0] and return the previous mask.
REQ-021 n=3 SHALL return bit31 = |(pending & mask), bits[4:0] = index of lowest set bit of pending & mask (0 when none), other bits 0.
REQ-022 n=5..7 SHALL return 0 without side effects; n=4 per REQ-027.
REQ-023 Simultaneous edge-set and n=1 clear of the same bit SHALL leave the bit set.
REQ-024 done SHALL be low in every cycle not following an accepted operation; result SHALL be 0 when done is low.

Reset
REQ-025 reset SHALL clear synchronizer flops, edge history, pending, mask, interrupt, done, result and any timestamp state immediately.
REQ-026 An operation accepted in the cycle reset asserts SHALL be discarded; no done SHALL follow reset release.

Configuration
REQ-027 With IRQ_TIMESTAMP_EN defined: a 32-bit free-running cycle counter (wraps 0xFFFFFFFF->0) SHALL be captured when interrupt goes 0->1; n=4 SHALL return the captured value. Without it: no counter, n=4 SHALL return 0.

Structure
REQ-028 Package irq_event_pkg SHALL hold opcode constants (OP_READ=0, OP_CLEAR=1, OP_MASK=2, OP_PRIO=3, OP_TSTAMP=4) and the 32-bit data width constant.
REQ-029 Sub-module irq_edge_sync SHALL implement one synchronizer plus edge detector, instantiated NUM_EVENTS times.

Verification
REQ-030 mask=0xFF, pulse events[3] -> pending=0x08 by cycle SYNC_STAGES+2, interrupt=1 one cycle later; n=0 returns 0x00000008.
REQ-031 pending=0x0C, n=1 dataa=0x04 -> result 0x0000000C, pending 0x08, interrupt stays 1; n=1 dataa=0x08 -> interrupt 0.
REQ-032 mask=0x00, event 5 edge -> pending=0x20, interrupt 0; n=2 dataa=0x20 -> result 0x00, interrupt 1 next cycle; n=3 -> 0x80000005.
REQ-033 Edge on bit 2 timed to land with n=1 dataa=0x04 -> pending bit 2 remains 1.
REQ-034 start with clk_en low -> no done; three back-to-back starts with clk_en high -> three consecutive done pulses.
REQ-035 IRQ_TIMESTAMP_EN: interrupt rises at counter value 0x00000040 -> n=4 returns 0x00000040; reset mid-operation -> all outputs 0, no done.
